// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
// Holds the FSM encoding, the chunk-count function and the signed saturation limits.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand the saturation helpers can describe; callers cast down to WIDTH.
  localparam int MAX_W = 1024;

  function automatic int n_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic logic [MAX_W-1:0] signed_max(input int width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] signed_min(input int width);
    return MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from 1-bit full-adder cells.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);
  logic [CHUNK:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (s_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign c_o     = carry[CHUNK];
  assign c_msb_o = carry[CHUNK-1];
endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract engine processing CHUNK bits per clock.
// Optional saturation on signed overflow is enabled by defining CHUNKED_ADDER_SAT_EN.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CHUNKED_ADDER_SAT_EN
  input  logic             sat,
`endif
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N_CHUNKS = n_chunks(WIDTH, CHUNK);
  localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CHUNKS - 1);
`ifdef CHUNKED_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
`ifdef CHUNKED_ADDER_SAT_EN
  logic             sat_q, sat_d;
`endif

  logic [CHUNK-1:0]       ch_sum;
  logic                   ch_co;
  logic                   ch_cmsb;
  logic [WIDTH+CHUNK-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;

  // Operands shift right each cycle so the adder always sees the low chunk.
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a_i     (a_q[CHUNK-1:0]),
    .b_i     (bx_q[CHUNK-1:0]),
    .c_i     (c_q),
    .s_o     (ch_sum),
    .c_o     (ch_co),
    .c_msb_o (ch_cmsb)
  );

  // Result fills from the top; after N_CHUNKS shifts chunk 0 lands at bit 0.
  assign res_cat   = {ch_sum, res_q};
  assign res_shift = res_cat[WIDTH+CHUNK-1:CHUNK];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    bx_d    = bx_q;
    c_d     = c_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef CHUNKED_ADDER_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      RUN: begin
        a_d   = a_q >> CHUNK;
        bx_d  = bx_q >> CHUNK;
        c_d   = ch_co;
        res_d = res_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = res_shift;
          cout_d  = ch_co;
          ovf_d   = ch_co ^ ch_cmsb;
`ifdef CHUNKED_ADDER_SAT_EN
          // On overflow both operands share a sign; A's MSB is still in the low chunk.
          if (sat_q && (ch_co ^ ch_cmsb)) begin
            sum_d = a_q[CHUNK-1] ? SMIN : SMAX;
          end
`endif
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          bx_d    = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
`ifdef CHUNKED_ADDER_SAT_EN
          sat_d   = sat;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      bx_q    <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef CHUNKED_ADDER_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      c_q     <= c_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef CHUNKED_ADDER_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder at WIDTH=16, CHUNK=4.
// Stimulus pushes expected results; a negedge monitor pops them on each done pulse.
module tb_chunked_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
`ifdef CHUNKED_ADDER_SAT_EN
  logic        sat = 1'b0;
`endif
  logic [15:0] sum;
  logic        cout, ovf, busy, done;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
`ifdef CHUNKED_ADDER_SAT_EN
    .sat   (sat),
`endif
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("cout", 32'(cout), 32'(e.co));
        check("ovf", 32'(ovf), 32'(e.ov));
      end
    end
  end

  // Drives start for one edge; returns just after the accepting edge.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                       input logic isub, input logic isat, input logic push,
                       input logic [15:0] es, input logic eco, input logic eov);
    @(negedge clk);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
`ifdef CHUNKED_ADDER_SAT_EN
    sat = isat;
`endif
    if (push) exp_q.push_back('{s: es, co: eco, ov: eov});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " done"}, 32'(done), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: busy for 4 cycles after the start edge, then done.
    issue(16'h1234, 16'h4321, 0, 0, 0, 1, 16'h5555, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lat busy", 32'(busy), 32'd1);
      check("lat done low", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("lat done", 32'(done), 32'd1);
    check("lat busy low", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("hold sum", 32'(sum), 32'h5555);
    check("idle done", 32'(done), 32'd0);

    issue(16'hFFFF, 16'h0001, 0, 0, 0, 1, 16'h0000, 1, 0); wait_done("wrap");
    issue(16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0001, 0, 0); wait_done("cin");
    issue(16'h7FFF, 16'h0001, 0, 0, 0, 1, 16'h8000, 0, 1); wait_done("povf");
    issue(16'h0005, 16'h0007, 0, 1, 0, 1, 16'hFFFE, 0, 0); wait_done("sub borrow");
    issue(16'h8000, 16'h0001, 0, 1, 0, 1, 16'h7FFF, 1, 1); wait_done("sub ovf");
`ifdef CHUNKED_ADDER_SAT_EN
    issue(16'h7FFF, 16'h0001, 0, 0, 1, 1, 16'h7FFF, 0, 1); wait_done("sat pos");
    issue(16'h8000, 16'h8000, 0, 0, 1, 1, 16'h8000, 1, 1); wait_done("sat neg");
`endif

    // start during RUN must be ignored.
    issue(16'h0001, 16'h0002, 0, 0, 0, 1, 16'h0003, 0, 0);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignore");

    // Back-to-back: start held in the DONE cycle.
    issue(16'h1111, 16'h2222, 0, 0, 0, 1, 16'h3333, 0, 0);
    wait_done("b2b first");
    a = 16'h00FF; b = 16'h0F01; cin = 1'b0; sub = 1'b0; start = 1'b1;
`ifdef CHUNKED_ADDER_SAT_EN
    sat = 1'b0;
`endif
    exp_q.push_back('{s: 16'h1000, co: 1'b0, ov: 1'b0});
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b busy", 32'(busy), 32'd1);
    check("b2b done low", 32'(done), 32'd0);
    wait_done("b2b second");
    repeat (3) @(negedge clk);
    check("b2b hold", 32'(sum), 32'h1000);

    // Reset during the second RUN cycle abandons the operation.
    issue(16'h1234, 16'h1111, 0, 0, 0, 0, 16'h0000, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst done", 32'(done), 32'd0);
    check("mrst sum", 32'(sum), 32'd0);
    check("mrst cout", 32'(cout), 32'd0);
    begin
      int nd;
      nd = 0;
      repeat (10) begin
        @(negedge clk);
        if (done) nd++;
      end
      check("mrst no done", 32'(nd), 32'd0);
    end

    issue(16'hA5A5, 16'h5A5A, 1, 0, 0, 1, 16'h0000, 1, 0); wait_done("post rst");

    repeat (2) @(negedge clk);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock.
- Trades latency for area against a flat ripple adder.
- Sits beside the arithmetic cells as the reusable wide-add engine for datapaths that tolerate WIDTH/CHUNK-cycle latency.
- Start/busy/done handshake; result, carry-out and signed overflow held until the next operation.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of CHUNK, and at least 2.
- CHUNK, 4, bits added per clock cycle. Must satisfy 1 <= CHUNK <= WIDTH.
- N_CHUNKS (localparam), WIDTH/CHUNK, number of processing cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request an operation; sampled only when busy=0
- sub  input  1  0: a+b+cin; 1: a-b (computed as a+~b+1, cin ignored); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in for add mode; sampled with start
- sum  output  WIDTH  registered result
- cout  output  1  final carry-out (in sub mode 1 = no borrow)
- ovf  output  1  two's-complement signed overflow of the final result
- busy  output  1  high while the operation is in progress
- done  output  1  single-cycle completion pulse

Behaviour:
- Reset: rst_n=0 sampled at an edge gives, from the next cycle, state IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, chunk counter=0, internal operand and carry registers=0.
- Reset mid-operation abandons the operation. No done pulse is produced and no partial result becomes visible.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Transitions:
  - IDLE with start=1: latch a, b, the effective B (b, or ~b when sub=1) and the initial carry (cin when sub=0, 1 when sub=1). Clear counter, go to RUN.
  - IDLE with start=0: stay in IDLE.
  - RUN: each edge adds chunk[counter] of A and effective B with the running carry. Write the chunk result into the result shift/slice register, update the carry, increment the counter.
  - RUN at the edge processing chunk N_CHUNKS-1: register sum, cout = final carry, ovf = carry into MSB XOR carry out of MSB, go to DONE.
  - DONE with start=1: accept the new operation exactly as in IDLE (back-to-back, no idle bubble), go to RUN.
  - DONE with start=0: go to IDLE.
- start while busy=1 is ignored. Operands are not resampled, and no error is flagged.
- Latency: start sampled at edge E0; done=1 in the cycle following edge E(N_CHUNKS). Throughput is one operation per N_CHUNKS+1 cycles.
- sum, cout and ovf change only at the completing edge and hold through IDLE until the next completion.
- Arithmetic is modulo 2^WIDTH with no implicit extension.
- CHUNK=WIDTH: degenerate case with a single RUN cycle; must work.

Optional Feature:
- Macro: CHUNKED_ADDER_SAT_EN.
- When defined:
  - Extra input port "sat" (1 bit), sampled with start.
  - With sat=1 and ovf=1, sum clamps to the signed max (0x7FFF for WIDTH=16) if the operand-sign case overflowed positive, or the signed min (0x8000) if it overflowed negative.
  - ovf still reports 1. cout is unaffected.
- When not defined: no sat port; the result always wraps.

Decomposition:
- Shared package adder_pkg:
  - state enum (IDLE, RUN, DONE)
  - function computing N_CHUNKS
  - signed max/min constant helpers
- One natural sub-module: chunk_adder.
  - Combinational CHUNK-bit ripple adder built from 1-bit full-adder cells.
  - Outputs: chunk sum, carry-out and carry-into-MSB (the last feeds ovf).
- The FSM, counter and registers stay in the top module.

Test Plan (WIDTH=16, CHUNK=4):
- a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0. done high exactly 4 cycles after the start edge; busy high for the 4 cycles before.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
- a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1, cout=0. With CHUNKED_ADDER_SAT_EN and sat=1 -> sum=0x7FFF, ovf=1.
- sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- start pulsed with new operands during RUN -> ignored, original result delivered. start held high in the DONE cycle -> new operation accepted and busy=1 on the next cycle.
- rst_n=0 for one edge during the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0. No done pulse follows.
